// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D), one transaction at a time.
// Stores are word-aligned here: address, byte-write mask and replicated write data come from funct3 and addr[1:0].
module mem_port_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req_valid,
    output logic            i_req_ready,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_resp_valid,
    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic            d_we,
    input  logic [2:0]      d_funct3,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_resp_valid,
    output logic            d_resp_err,
    output logic [XLEN-1:0] resp_rdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wmask,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // Halfwords need even offsets, words need offset 0; codes x11 are never valid.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] o);
        logic r;
        case (f3)
            3'b000, 3'b100: r = 1'b0;
            3'b001, 3'b101: r = o[0];
            3'b010, 3'b110: r = (o != 2'b00);
            default:        r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] o);
        logic [3:0] m;
        case (f3)
            3'b000, 3'b100: m = 4'b0001 << o;
            3'b001, 3'b101: m = 4'b0011 << o;
            default:        m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] r;
        case (f3)
            3'b000, 3'b100: r = {4{wd[7:0]}};
            3'b001, 3'b101: r = {2{wd[15:0]}};
            default:        r = wd;
        endcase
        return r;
    endfunction

    state_t          state_q, state_d;
    logic            d_prio_q, d_prio_d;
    logic            own_d_q, own_d_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]      mem_wmask_q, mem_wmask_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            i_resp_valid_q, i_resp_valid_d;
    logic            d_resp_valid_q, d_resp_valid_d;
    logic            d_resp_err_q, d_resp_err_d;
    logic            grant_d_s, grant_i_s;

    // Round-robin grant: on a tie the requester flagged by d_prio_q wins.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (rst_n && (state_q == ST_IDLE)) begin
            grant_d_s = d_req_valid & (~i_req_valid | d_prio_q);
            grant_i_s = i_req_valid & ~grant_d_s;
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Next-state and datapath: latch fields on accept, hold through ISSUE, capture the response in WAIT.
    always_comb begin
        state_d        = state_q;
        d_prio_d       = d_prio_q;
        own_d_d        = own_d_q;
        mem_addr_d     = mem_addr_q;
        mem_wmask_d    = mem_wmask_q;
        mem_wdata_d    = mem_wdata_q;
        resp_rdata_d   = resp_rdata_q;
        i_resp_valid_d = 1'b0;
        d_resp_valid_d = 1'b0;
        d_resp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_d_s) begin
                    d_prio_d = 1'b0;
                    if (is_misaligned(d_funct3, d_addr[1:0])) begin
                        d_resp_valid_d = 1'b1;
                        d_resp_err_d   = 1'b1;
                        resp_rdata_d   = '0;
                    end else begin
                        own_d_d     = 1'b1;
                        mem_addr_d  = d_addr & WORD_MASK;
                        mem_wmask_d = d_we ? store_mask(d_funct3, d_addr[1:0]) : 4'b0000;
                        mem_wdata_d = d_we ? store_data(d_funct3, d_wdata) : '0;
                        state_d     = ST_ISSUE;
                    end
                end else if (grant_i_s) begin
                    d_prio_d    = 1'b1;
                    own_d_d     = 1'b0;
                    mem_addr_d  = i_addr & WORD_MASK;
                    mem_wmask_d = 4'b0000;
                    mem_wdata_d = '0;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    resp_rdata_d   = mem_rdata;
                    i_resp_valid_d = ~own_d_q;
                    d_resp_valid_d = own_d_q;
                    state_d        = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending response and hands the next tie to D.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            d_prio_q       <= 1'b1;
            own_d_q        <= 1'b0;
            mem_addr_q     <= '0;
            mem_wmask_q    <= 4'b0000;
            mem_wdata_q    <= '0;
            resp_rdata_q   <= '0;
            i_resp_valid_q <= 1'b0;
            d_resp_valid_q <= 1'b0;
            d_resp_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            d_prio_q       <= d_prio_d;
            own_d_q        <= own_d_d;
            mem_addr_q     <= mem_addr_d;
            mem_wmask_q    <= mem_wmask_d;
            mem_wdata_q    <= mem_wdata_d;
            resp_rdata_q   <= resp_rdata_d;
            i_resp_valid_q <= i_resp_valid_d;
            d_resp_valid_q <= d_resp_valid_d;
            d_resp_err_q   <= d_resp_err_d;
        end
    end

    assign i_req_ready   = grant_i_s;
    assign d_req_ready   = grant_d_s;
    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_addr      = mem_addr_q;
    assign mem_wmask     = mem_wmask_q;
    assign mem_wdata     = mem_wdata_q;
    assign resp_rdata    = resp_rdata_q;
    assign i_resp_valid  = i_resp_valid_q;
    assign d_resp_valid  = d_resp_valid_q;
    assign d_resp_err    = d_resp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model of
// arbitration, alignment rules, store byte lanes and response timing.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [31:0] i_addr;
    logic        d_req_valid, d_req_ready, d_we, d_resp_valid, d_resp_err;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_wdata, resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int checks = 0;
    int errors = 0;
    bit model_d_prio;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_resp_valid(i_resp_valid),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
        .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_err(d_resp_err), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".mem_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
        check({tag, ".mem_addr"}, mem_addr, 32'd0);
        check({tag, ".mem_wmask"}, {28'd0, mem_wmask}, 32'd0);
        check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        check({tag, ".i_resp_valid"}, {31'd0, i_resp_valid}, 32'd0);
        check({tag, ".d_resp_valid"}, {31'd0, d_resp_valid}, 32'd0);
        check({tag, ".d_resp_err"}, {31'd0, d_resp_err}, 32'd0);
        check({tag, ".resp_rdata"}, resp_rdata, 32'd0);
    endtask

    // One complete transaction, starting at posedge+1 with the DUT idle; ends at the cycle the
    // response (or error) is visible, which is also a cycle where a new request may be accepted.
    task automatic txn(input bit iv, input bit dv, input logic [31:0] ia, input bit we,
                       input logic [2:0] f3, input logic [31:0] da, input logic [31:0] wd,
                       input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                       output bit got_d);
        bit          win_d, win_i, err;
        int          bytes, o;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_mask;
        i_req_valid = iv;   i_addr = ia;
        d_req_valid = dv;   d_we = we; d_funct3 = f3; d_addr = da; d_wdata = wd;
        #1;
        win_d = dv && (!iv || model_d_prio);
        win_i = iv && !win_d;
        got_d = d_req_ready;
        check("i_req_ready", {31'd0, i_req_ready}, {31'd0, win_i});
        check("d_req_ready", {31'd0, d_req_ready}, {31'd0, win_d});
        if (win_d || win_i) model_d_prio = win_i;
        bytes = 1 << f3[1:0];
        o = da % 4;
        err = win_d && ((f3[1:0] == 2'd3) || ((da % bytes) != 0));
        exp_addr = ((win_d ? da : ia) / 4) * 4;
        exp_mask = 4'd0;
        exp_wdata = 32'd0;
        if (win_d && we && !err) begin
            for (int b = 0; b < bytes; b++) exp_mask[o + b] = 1'b1;
            for (int b = 0; b < 4; b++) exp_wdata[8*b +: 8] = wd[8*(b % bytes) +: 8];
        end
        tick();
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        d_funct3 = 3'($urandom); d_we = 1'($urandom);
        if (!win_d && !win_i) begin
            check("idle.mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
            return;
        end
        if (err) begin
            check("err.d_resp_valid", {31'd0, d_resp_valid}, 32'd1);
            check("err.d_resp_err", {31'd0, d_resp_err}, 32'd1);
            check("err.resp_rdata", resp_rdata, 32'd0);
            check("err.i_resp_valid", {31'd0, i_resp_valid}, 32'd0);
            check("err.mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
            return;
        end
        for (int k = 0; k <= rdy_dly; k++) begin
            mem_req_ready = (k == rdy_dly);
            mem_resp_valid = 1'($urandom);
            mem_rdata = $urandom;
            check("issue.mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
            check("issue.mem_addr", mem_addr, exp_addr);
            check("issue.mem_wmask", {28'd0, mem_wmask}, {28'd0, exp_mask});
            if (win_d && we) check("issue.mem_wdata", mem_wdata, exp_wdata);
            check("issue.resp_valid", {30'd0, i_resp_valid, d_resp_valid}, 32'd0);
            tick();
        end
        mem_req_ready = 1'b0;
        for (int k = 0; k <= rsp_dly; k++) begin
            mem_resp_valid = (k == rsp_dly);
            mem_rdata = (k == rsp_dly) ? rdata : $urandom;
            check("wait.mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
            check("wait.resp_valid", {30'd0, i_resp_valid, d_resp_valid}, 32'd0);
            tick();
        end
        mem_resp_valid = 1'b0;
        check("resp.i_resp_valid", {31'd0, i_resp_valid}, {31'd0, win_i});
        check("resp.d_resp_valid", {31'd0, d_resp_valid}, {31'd0, win_d});
        check("resp.d_resp_err", {31'd0, d_resp_err}, 32'd0);
        check("resp.resp_rdata", resp_rdata, rdata);
    endtask

    initial begin
        bit          got_d;
        bit          iv, dv, we;
        logic [2:0]  f3;
        logic [2:0]  st_codes [5];
        st_codes[0] = 3'b000; st_codes[1] = 3'b001; st_codes[2] = 3'b010;
        st_codes[3] = 3'b011; st_codes[4] = 3'b111;

        rst_n = 1'b0;
        i_req_valid = 1'b0; i_addr = 32'd0;
        d_req_valid = 1'b0; d_we = 1'b0; d_funct3 = 3'd0; d_addr = 32'd0; d_wdata = 32'd0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'd0;
        model_d_prio = 1'b1;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Fetch, immediate memory: resp_valid three cycles after accept.
        txn(1'b1, 1'b0, 32'h0000_0100, 1'b0, 3'd0, 32'd0, 32'd0, 0, 0, 32'hDEAD_BEEF, got_d);
        // Byte store to offset 3.
        txn(1'b0, 1'b1, 32'd0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 1, 1, 32'h0BAD_F00D, got_d);
        check("sb.resp_rdata_hold", resp_rdata, 32'h0BAD_F00D);
        // Misaligned halfword store: error, never issued.
        txn(1'b0, 1'b1, 32'd0, 1'b1, 3'b001, 32'h0000_0201, 32'h0000_1234, 0, 0, 32'd0, got_d);
        txn(1'b0, 1'b0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 0, 0, 32'd0, got_d);
        txn(1'b0, 1'b0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 0, 0, 32'd0, got_d);
        check("sh_err.rdata_hold", resp_rdata, 32'd0);

        // Reset while waiting with the response arriving in the same cycle.
        txn(1'b1, 1'b0, 32'h0000_0500, 1'b0, 3'd0, 32'd0, 32'd0, 0, 0, 32'h1111_2222, got_d);
        d_req_valid = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h0000_0044;
        #1;
        check("rst.d_req_ready", {31'd0, d_req_ready}, 32'd1);
        tick();
        d_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        check("rst.mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
        tick();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        rst_n = 1'b1;
        mem_resp_valid = 1'b0;
        model_d_prio = 1'b1;
        check_all_zero("rst_mid");
        tick();
        check("rst.late_resp", {30'd0, i_resp_valid, d_resp_valid}, 32'd0);

        // Both valid every time: grants alternate starting with D, issue held for 3 cycles.
        for (int k = 0; k < 6; k++) begin
            txn(1'b1, 1'b1, 32'h0000_0400 + 32'(4 * k), 1'b1, 3'b010, 32'h0000_0800 + 32'(4 * k),
                $urandom, 3, $urandom_range(0, 2), $urandom, got_d);
            check("alt_grant", {31'd0, got_d}, {31'd0, (k % 2 == 0)});
        end

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            iv = 1'($urandom);
            dv = 1'($urandom);
            we = 1'($urandom);
            f3 = we ? st_codes[$urandom_range(0, 4)] : 3'($urandom);
            txn(iv, dv, $urandom, we, f3, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom, got_d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (requester I) and the load/store path (requester D).
- Sequences one outstanding transaction at a time: accept, issue, await response, return.
- For stores, generates word-aligned address, shifted write data and byte-write mask from funct3 and addr[1:0].
- Load data is returned as the raw word; byte/half extraction stays in the writeback alignment logic.

Parameters:
XLEN, 32, data/address width (must be 32)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
i_req_valid  in  1  fetch request
i_req_ready  out  1  fetch request accepted this cycle
i_addr  in  XLEN  fetch address (word aligned)
i_resp_valid  out  1  fetch data valid, 1-cycle pulse
d_req_valid  in  1  load/store request
d_req_ready  out  1  load/store request accepted this cycle
d_we  in  1  1 = store, 0 = load
d_funct3  in  3  RV32 width code (000 B, 001 H, 010 W, 1xx loads unsigned)
d_addr  in  XLEN  byte address
d_wdata  in  XLEN  store data, LSB-justified
d_resp_valid  out  1  load data / store ack, 1-cycle pulse
d_resp_err  out  1  misaligned access, qualified by d_resp_valid
resp_rdata  out  XLEN  returned word, shared by both requesters
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_addr  out  XLEN  word address (low 2 bits zero)
mem_wmask  out  4  byte-write enables; 0000 = read
mem_wdata  out  XLEN  shifted store data
mem_resp_valid  in  1  memory response (reads and writes)
mem_rdata  in  XLEN  memory read word

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = D.
- FSM states:
  - IDLE: if any req_valid, grant one, pulse its req_ready combinationally, latch fields, go to ISSUE.
  - ISSUE: mem_req_valid=1 with latched fields, held stable until mem_req_ready; then go to WAIT.
  - WAIT: on mem_resp_valid, register mem_rdata into resp_rdata and pulse the owner's resp_valid next cycle; go to IDLE.
- mem_resp_valid is ignored outside WAIT.
- Arbitration:
  - Only one requester valid: that one wins.
  - Both valid: the requester not granted last wins (round-robin).
  - Pointer updates on every grant, including error grants.
- Minimum latency: accept at cycle 0, mem_req_valid cycles 1..n, resp_valid one cycle after mem_resp_valid. With ready and response immediate: accept@0, issue@1, resp@2 from memory, resp_valid@3.
- A new request may be accepted in the same cycle resp_valid pulses, since state is IDLE then.
- Store mask and data, where o = addr[1:0]:
  - SB: mask = 0001<<o; wdata = {4{byte}}.
  - SH: mask = 0011<<o; wdata = {2{half}}.
  - SW: mask = 1111.
  - Loads: mask = 0000.
- Misalignment:
  - Error cases: SH/LH/LHU with o ∈ {1,3}; SW/LW with o≠0; funct3 011 or 111.
  - Request is accepted but no memory request is issued; state stays IDLE.
  - d_resp_valid=1, d_resp_err=1, resp_rdata=0 on the next cycle.
- mem_addr = {addr[31:2],2'b00}.
- I requests are never checked; i_addr[1:0] is dropped.
- Requester fields are sampled only on the accept cycle; later changes have no effect.
- Reset mid-transaction: return to IDLE next edge, drop the pending response, clear all outputs. The memory is reset by the same rst_n.
- d_resp_err=0 on every non-error response; resp_rdata holds its value between responses.

Test Plan:
- Fetch only: i_addr=0x100, mem ready immediate, mem_rdata=0xDEADBEEF one cycle after issue -> mem_wmask=0000, mem_addr=0x100, i_resp_valid pulses with resp_rdata=0xDEADBEEF exactly 3 cycles after accept.
- SB to 0x203, d_wdata=0x000000A5 -> mem_addr=0x200, mem_wmask=1000, mem_wdata=0xA5A5A5A5; d_resp_valid after mem_resp_valid, d_resp_err=0.
- SH to 0x201 -> accepted, no mem_req_valid ever asserted, next cycle d_resp_valid=1, d_resp_err=1, resp_rdata=0.
- Both valid every cycle for 6 transactions -> grants alternate D,I,D,I,D,I; no requester starves. mem_req_ready held low 3 cycles -> mem_addr/mem_wmask/mem_wdata stable throughout.
- rst_n low during WAIT with mem_resp_valid arriving the same cycle -> no resp_valid pulse, all outputs 0 next cycle, next grant goes to D.
